ep_multibin_decoder: RTL and testbench

- Parametrised successor to the single-bin bypass (EP) arithmetic decoder.
- Decodes up to BINS_PER_CYCLE bypass bins per clock for a requested burst of 1..MAX_BINS bins.
- Self-initialises its value register from the byte stream and pulls bytes through a valid/ready handshake, stalling when data is absent.
- Sits beside the context-coded engine: takes the current range in, and exports value/bits-needed for handoff back.

---
 rtl/ep_dec_pkg.sv | 27 ++
 rtl/ep_bin_stage.sv | 46 ++++
 rtl/ep_multibin_decoder.sv | 194 +++++++++++++++++++
 tb/tb_ep_multibin_decoder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ep_dec_pkg.sv
// Shared types and constants for the multi-bin bypass arithmetic decoder.
// Holds the FSM state encoding, datapath widths and the range scaling helper.
package ep_dec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT0,
        ST_INIT1,
        ST_READY,
        ST_DECODE,
        ST_DONE
    } state_t;

    localparam int VALUE_W     = 17;
    localparam int SCALE_SHIFT = 7;

    localparam logic [8:0]        INIT_RANGE       = 9'd510;
    localparam logic signed [3:0] BITS_NEEDED_INIT = -4'sd8;

    // Range aligned with the value register for the bypass compare.
    function automatic logic [VALUE_W-1:0] scale_range(
        input logic [8:0] r
    );
        return VALUE_W'(r) << SCALE_SHIFT;
    endfunction

endpackage

// File: rtl/ep_bin_stage.sv
// Combinational single-bin bypass decode step; chained once per bin per cycle.
// Ports: enable, value_in, bits_needed_in, range, byte_in in;
//        value_out, bits_needed_out, bin, needs_byte out.
module ep_bin_stage
    import ep_dec_pkg::*;
(
    input  logic                enable,
    input  logic [VALUE_W-1:0]  value_in,
    input  logic signed [3:0]   bits_needed_in,
    input  logic [8:0]          range,
    input  logic [7:0]          byte_in,
    output logic [VALUE_W-1:0]  value_out,
    output logic signed [3:0]   bits_needed_out,
    output logic                bin,
    output logic                needs_byte
);

    logic [VALUE_W-1:0] shifted;
    logic [VALUE_W-1:0] filled;
    logic [VALUE_W-1:0] scaled;
    logic signed [3:0]  bn_inc;

    always_comb begin
        // Stored value stays below 2^16, so dropping the MSB is lossless.
        shifted    = value_in << 1;
        bn_inc     = bits_needed_in + 4'sd1;
        needs_byte = enable && !bn_inc[3];
        filled     = needs_byte ? shifted + VALUE_W'(byte_in) : shifted;
        scaled     = scale_range(range);

        value_out       = value_in;
        bits_needed_out = bits_needed_in;
        bin             = 1'b0;

        if (enable) begin
            bits_needed_out = needs_byte ? BITS_NEEDED_INIT : bn_inc;
            if (filled >= scaled) begin
                bin       = 1'b1;
                value_out = filled - scaled;
            end else begin
                value_out = filled;
            end
        end
    end

endmodule

// File: rtl/ep_multibin_decoder.sv
// Bypass-bin arithmetic decoder resolving up to BINS_PER_CYCLE bins per clock.
// Ports: byte stream valid/ready in, burst request in, bins/value/bits out.
module ep_multibin_decoder
    import ep_dec_pkg::*;
#(
    parameter  int BINS_PER_CYCLE = 4,
    parameter  int MAX_BINS       = 32,
    parameter  int CNT_W          = 7,
    localparam int RW             = $clog2(MAX_BINS + 1)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                init_start,
    input  logic [7:0]          byte_data,
    input  logic                byte_valid,
    output logic                byte_ready,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [RW-1:0]       req_count,
    input  logic [8:0]          range_in,
    output logic                bins_valid,
    output logic [MAX_BINS-1:0] bins_out,
    output logic [16:0]         value_out,
    output logic signed [3:0]   bits_needed_out,
    output logic                busy,
    output logic [CNT_W-1:0]    cycle_count
);

    localparam logic [RW-1:0] BPC_W = RW'(BINS_PER_CYCLE);

    state_t state;
    state_t state_nxt;

    logic [VALUE_W-1:0]  value;
    logic signed [3:0]   bits_needed;
    logic [8:0]          range;
    logic [RW-1:0]       remaining;
    logic [MAX_BINS-1:0] bins_sr;
    logic [MAX_BINS-1:0] bins_nxt;
    logic [CNT_W-1:0]    cycles;

    logic [VALUE_W-1:0] cv    [0:BINS_PER_CYCLE];
    logic signed [3:0]  cb    [0:BINS_PER_CYCLE];
    logic               taken [0:BINS_PER_CYCLE];
    logic               en    [0:BINS_PER_CYCLE-1];
    logic               bin   [0:BINS_PER_CYCLE-1];
    logic               nb    [0:BINS_PER_CYCLE-1];

    logic          need_byte;
    logic          stall;
    logic          last;
    logic          accept;
    logic [RW-1:0] step;

    assign cv[0]    = value;
    assign cb[0]    = bits_needed;
    assign taken[0] = 1'b0;

    for (genvar i = 0; i < BINS_PER_CYCLE; i++) begin : g_stage
        assign en[i] = remaining > RW'(i);

        // Only the first stage that asks for a byte receives it.
        ep_bin_stage u_stage (
            .enable          (en[i]),
            .value_in        (cv[i]),
            .bits_needed_in  (cb[i]),
            .range           (range),
            .byte_in         (taken[i] ? 8'h00 : byte_data),
            .value_out       (cv[i+1]),
            .bits_needed_out (cb[i+1]),
            .bin             (bin[i]),
            .needs_byte      (nb[i])
        );

        assign taken[i+1] = taken[i] | nb[i];
    end

    assign need_byte = taken[BINS_PER_CYCLE];
    assign stall     = need_byte && !byte_valid;
    assign last      = remaining <= BPC_W;
    assign step      = last ? remaining : BPC_W;
    assign accept    = (state == ST_READY) && req_valid && !init_start;

    // Earliest bin of the cycle is shifted in first, ending nearest the MSB.
    always_comb begin
        bins_nxt = bins_sr;
        for (int i = 0; i < BINS_PER_CYCLE; i++) begin
            if (en[i]) begin
                bins_nxt = {bins_nxt[MAX_BINS-2:0], bin[i]};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (init_start) begin
            state_nxt = ST_INIT0;
        end else begin
            unique case (state)
                ST_IDLE:   state_nxt = ST_IDLE;
                ST_INIT0:  if (byte_valid) state_nxt = ST_INIT1;
                ST_INIT1:  if (byte_valid) state_nxt = ST_READY;
                ST_READY:  if (req_valid) state_nxt = ST_DECODE;
                ST_DECODE: if (!stall && last) state_nxt = ST_DONE;
                ST_DONE:   state_nxt = ST_READY;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        byte_ready = 1'b0;
        req_ready  = 1'b0;
        busy       = 1'b0;
        bins_valid = 1'b0;
        unique case (state)
            ST_INIT0, ST_INIT1: begin
                byte_ready = !init_start;
                busy       = 1'b1;
            end
            ST_READY: begin
                req_ready = !init_start;
            end
            ST_DECODE: begin
                byte_ready = need_byte && !init_start;
                busy       = 1'b1;
            end
            ST_DONE: begin
                bins_valid = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value       <= '0;
            bits_needed <= BITS_NEEDED_INIT;
            range       <= INIT_RANGE;
            remaining   <= '0;
            bins_sr     <= '0;
            cycles      <= '0;
        end else if (!init_start) begin
            unique case (state)
                ST_INIT0: begin
                    if (byte_valid) begin
                        value <= {1'b0, byte_data, 8'h00};
                    end
                end
                ST_INIT1: begin
                    if (byte_valid) begin
                        value[7:0]  <= byte_data;
                        bits_needed <= BITS_NEEDED_INIT;
                    end
                end
                ST_READY: begin
                    if (accept) begin
                        range     <= range_in;
                        remaining <= (req_count == '0) ? RW'(1)
                                                       : req_count;
                        bins_sr   <= '0;
                        cycles    <= '0;
                    end
                end
                ST_DECODE: begin
                    cycles <= cycles + 1'b1;
                    if (!stall) begin
                        value       <= cv[BINS_PER_CYCLE];
                        bits_needed <= cb[BINS_PER_CYCLE];
                        bins_sr     <= bins_nxt;
                        remaining   <= remaining - step;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bins_out        = bins_sr;
    assign value_out       = value;
    assign bits_needed_out = bits_needed;
    assign cycle_count     = cycles;

endmodule

// File: tb/tb_ep_multibin_decoder.sv
// Directed self-checking bench for ep_multibin_decoder.
// Drives and samples on the falling clock edge.
module tb_ep_multibin_decoder;

    localparam int BPC = 4;
    localparam int MB  = 32;
    localparam int CW  = 7;
    localparam int RW  = $clog2(MB + 1);

    logic          clk;
    logic          reset_n;
    logic          init_start;
    logic [7:0]    byte_data;
    logic          byte_valid;
    logic          byte_ready;
    logic          req_valid;
    logic          req_ready;
    logic [RW-1:0] req_count;
    logic [8:0]    range_in;
    logic          bins_valid;
    logic [MB-1:0] bins_out;
    logic [16:0]   value_out;
    logic signed [3:0] bits_needed_out;
    logic          busy;
    logic [CW-1:0] cycle_count;

    int n_err;
    int n_checks;

    ep_multibin_decoder #(
        .BINS_PER_CYCLE (BPC),
        .MAX_BINS       (MB),
        .CNT_W          (CW)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .init_start      (init_start),
        .byte_data       (byte_data),
        .byte_valid      (byte_valid),
        .byte_ready      (byte_ready),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_count       (req_count),
        .range_in        (range_in),
        .bins_valid      (bins_valid),
        .bins_out        (bins_out),
        .value_out       (value_out),
        .bits_needed_out (bits_needed_out),
        .busy            (busy),
        .cycle_count     (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts on a falling edge; ends on the falling edge in READY.
    task automatic do_init(input logic [7:0] b0, input logic [7:0] b1);
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        byte_valid = 1'b1;
        byte_data  = b0;
        @(negedge clk);
        byte_data  = b1;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    // Issues one burst; DECODE cycles 1..stall_n see byte_valid low.
    task automatic burst(
        input  logic [8:0] rng,
        input  int         cnt,
        input  int         stall_n,
        output int         consumed,
        output bit         done
    );
        range_in  = rng;
        req_count = RW'(cnt);
        req_valid = 1'b1;
        #1;
        check("req_ready_at_accept", 32'(req_ready), 1);
        @(negedge clk);
        req_valid = 1'b0;
        consumed  = 0;
        done      = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            byte_valid = (c == 0) || (c > stall_n);
            #1;
            if (byte_valid && byte_ready) consumed++;
            if (c >= 1 && c <= stall_n)
                check("stall_byte_ready", 32'(byte_ready), 1);
            @(negedge clk);
            if (bins_valid) done = 1'b1;
        end
        byte_valid = 1'b0;
        check("bins_valid_seen", 32'(done), 1);
    endtask

    int consumed;
    bit done;

    initial begin
        n_err      = 0;
        n_checks   = 0;
        reset_n    = 1'b0;
        init_start = 1'b0;
        byte_data  = 8'h00;
        byte_valid = 1'b0;
        req_valid  = 1'b0;
        req_count  = '0;
        range_in   = 9'd0;

        repeat (2) @(negedge clk);
        check("rst_value", 32'(value_out), 0);
        check("rst_bits", 32'(bits_needed_out), -8);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_byte_ready", 32'(byte_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_bins_valid", 32'(bins_valid), 0);
        check("rst_bins", bins_out, 0);
        check("rst_cycles", 32'(cycle_count), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Init from two bytes.
        do_init(8'h8C, 8'hD1);
        check("init_value", 32'(value_out), 36049);
        check("init_bits", 32'(bits_needed_out), -8);
        check("init_req_ready", 32'(req_ready), 1);
        check("init_busy", 32'(busy), 0);

        // Four bins, no byte needed, byte_valid high must be ignored.
        burst(9'd289, 4, 0, consumed, done);
        check("b4_bins", bins_out, 32'hF);
        check("b4_value", 32'(value_out), 21904);
        check("b4_bits", 32'(bits_needed_out), -4);
        check("b4_cycles", 32'(cycle_count), 1);
        check("b4_consumed", 32'(consumed), 0);
        @(negedge clk);
        check("b4_valid_pulse", 32'(bins_valid), 0);
        check("b4_ready_again", 32'(req_ready), 1);
        check("b4_bins_held", bins_out, 32'hF);

        // Eight bins with one zero byte.
        do_init(8'h8C, 8'hD1);
        byte_data = 8'h00;
        burst(9'd289, 8, 0, consumed, done);
        check("b8_bins", bins_out, 32'hF9);
        check("b8_value", 32'(value_out), 17536);
        check("b8_bits", 32'(bits_needed_out), -8);
        check("b8_cycles", 32'(cycle_count), 2);
        check("b8_consumed", 32'(consumed), 1);
        @(negedge clk);

        // Same burst with a three-cycle byte stall.
        do_init(8'h8C, 8'hD1);
        byte_data = 8'h00;
        burst(9'd289, 8, 3, consumed, done);
        check("st_bins", bins_out, 32'hF9);
        check("st_value", 32'(value_out), 17536);
        check("st_bits", 32'(bits_needed_out), -8);
        check("st_cycles", 32'(cycle_count), 5);
        check("st_consumed", 32'(consumed), 1);
        @(negedge clk);

        // Single bin with maximum range.
        do_init(8'h8C, 8'hD1);
        burst(9'd510, 1, 0, consumed, done);
        check("b1_bins", bins_out, 32'h1);
        check("b1_value", 32'(value_out), 6818);
        check("b1_bits", 32'(bits_needed_out), -7);
        check("b1_cycles", 32'(cycle_count), 1);
        @(negedge clk);

        // init_start while stalled in the second DECODE cycle.
        do_init(8'h8C, 8'hD1);
        range_in   = 9'd289;
        req_count  = RW'(8);
        req_valid  = 1'b1;
        @(negedge clk);
        req_valid  = 1'b0;
        byte_valid = 1'b0;
        @(negedge clk);
        #1;
        check("ab_stall_ready", 32'(byte_ready), 1);
        check("ab_stall_busy", 32'(busy), 1);
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        #1;
        check("ab_no_valid", 32'(bins_valid), 0);
        check("ab_init0_ready", 32'(byte_ready), 1);
        check("ab_init0_req", 32'(req_ready), 0);
        byte_valid = 1'b1;
        byte_data  = 8'h12;
        @(negedge clk);
        check("ab_no_valid2", 32'(bins_valid), 0);
        byte_data  = 8'h34;
        @(negedge clk);
        byte_valid = 1'b0;
        check("ab_value", 32'(value_out), 32'h1234);
        check("ab_bits", 32'(bits_needed_out), -8);
        check("ab_req_ready", 32'(req_ready), 1);

        // Asynchronous reset in the middle of a burst.
        range_in  = 9'd289;
        req_count = RW'(8);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_value", 32'(value_out), 0);
        check("ar_bits", 32'(bits_needed_out), -8);
        check("ar_busy", 32'(busy), 0);
        check("ar_byte_ready", 32'(byte_ready), 0);
        check("ar_req_ready", 32'(req_ready), 0);
        check("ar_bins", bins_out, 0);
        check("ar_cycles", 32'(cycle_count), 0);
        check("ar_bins_valid", 32'(bins_valid), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
